// File: rtl/dm_resp_if.sv
// Data-memory port bundle between a cpu (master) and a memory responder (slave).
interface dm_resp_if #(
    parameter int unsigned DATA_W = 16
);
    logic [15:0]       addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] rd_data;
    logic              rdy;
    logic              busy;
    logic              ovr;

    modport master (
        output addr, re, we, wrt_data,
        input  rd_data, rdy, busy, ovr
    );

    modport slave (
        input  addr, re, we, wrt_data,
        output rd_data, rdy, busy, ovr
    );
endinterface

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accepts one request pulse, services it
// LATENCY clocks later, pulses rdy on completion and flags overruns.
module dm_resp #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LATENCY = 4
) (
    input logic       clk,
    input logic       rst_n,
    dm_resp_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dm_resp: LATENCY must be in 1..15");
        end
    endgenerate

    state_t             state;
    logic [3:0]         cnt;
    logic               op_wr;
    logic [ADDR_W-1:0]  addr_lat;
    logic [DATA_W-1:0]  data_lat;
    logic [DATA_W-1:0]  rd_data;
    logic               rdy;
    logic               busy;
    logic               ovr;
    logic               req;
    logic               commit_wr;
    logic               unused_addr;

    // Storage is deliberately left without reset.
    logic [DATA_W-1:0]  mem [0:(1 << ADDR_W) - 1];

    assign req         = bus.re | bus.we;
    // Address bits above ADDR_W alias onto the low words.
    assign unused_addr = ^bus.addr;
    // Write commits on the last WAIT edge; a reset in WAIT returns the FSM
    // to IDLE first, so an interrupted write never reaches the array.
    assign commit_wr   = (state == WAIT) && (cnt == '0) && op_wr;

    assign bus.rd_data = rd_data;
    assign bus.rdy     = rdy;
    assign bus.busy    = busy;
    assign bus.ovr     = ovr;

    // Storage write port, committed at the completion edge of a write.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[addr_lat] <= data_lat;
        end
    end

    // Request FSM: accept in IDLE/DONE, count down in WAIT, complete into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            addr_lat <= '0;
            data_lat <= '0;
            rd_data  <= '0;
            rdy      <= 1'b0;
            busy     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        // re&we together is a write.
                        op_wr    <= bus.we;
                        addr_lat <= bus.addr[ADDR_W-1:0];
                        data_lat <= bus.wrt_data;
                        cnt      <= 4'(LATENCY - 1);
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (req) begin
                        ovr <= 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_wr) begin
                            rd_data <= mem[addr_lat];
                        end
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: two instances (LATENCY=4/ADDR_W=16 and
// LATENCY=1/ADDR_W=8) checked every cycle against a timing/queue model.
module tb_dm_resp;
    logic clk;
    logic rst_n;

    dm_resp_if #(.DATA_W(16)) b0 ();
    dm_resp_if #(.DATA_W(16)) b1 ();

    dm_resp #(.DATA_W(16), .ADDR_W(16), .LATENCY(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    dm_resp #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driven stimulus per instance
    logic        r_in [2];
    logic        w_in [2];
    logic [15:0] a_in [2];
    logic [15:0] d_in [2];

    assign b0.re = r_in[0];
    assign b0.we = w_in[0];
    assign b0.addr = a_in[0];
    assign b0.wrt_data = d_in[0];
    assign b1.re = r_in[1];
    assign b1.we = w_in[1];
    assign b1.addr = a_in[1];
    assign b1.wrt_data = d_in[1];

    int checks = 0;
    int failures = 0;

    // Reference model: completion scheduled at accept_edge + LATENCY
    int          lat_m    [2];
    int          amask_m  [2];
    longint      edge_no;
    bit          inflight [2];
    longint      done_at  [2];
    bit          op_wr_m  [2];
    int          addr_m   [2];
    logic [15:0] data_m   [2];
    logic [15:0] exp_rd   [2];
    bit          rd_known [2];
    bit          exp_rdy  [2];
    bit          exp_busy [2];
    bit          exp_ovr  [2];
    logic [15:0] mem_m [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(input int i);
        return (i == 0) ? b0.rdy : b1.rdy;
    endfunction

    function automatic logic [15:0] get_rd(input int i);
        return (i == 0) ? b0.rd_data : b1.rd_data;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            inflight[i] = 0;
            exp_rd[i]   = 16'h0000;
            rd_known[i] = 1;
            exp_rdy[i]  = 0;
            exp_busy[i] = 0;
            exp_ovr[i]  = 0;
        end
    endtask

    task automatic model_edge(input int i, input longint e);
        bit req;
        bit was_busy;
        int key;
        req      = r_in[i] | w_in[i];
        was_busy = exp_busy[i];
        exp_rdy[i] = 0;
        if (req && was_busy) exp_ovr[i] = 1;
        if (inflight[i] && e == done_at[i]) begin
            key = i * 65536 + addr_m[i];
            if (op_wr_m[i]) begin
                mem_m[key] = data_m[i];
            end else if (mem_m.exists(key)) begin
                exp_rd[i]   = mem_m[key];
                rd_known[i] = 1;
            end else begin
                rd_known[i] = 0;
            end
            inflight[i] = 0;
            exp_rdy[i]  = 1;
        end
        if (req && !was_busy) begin
            inflight[i] = 1;
            done_at[i]  = e + lat_m[i];
            op_wr_m[i]  = w_in[i];
            addr_m[i]   = int'(a_in[i]) & amask_m[i];
            data_m[i]   = d_in[i];
        end
        exp_busy[i] = inflight[i];
    endtask

    task automatic compare_all();
        chk("rdy0", b0.rdy, exp_rdy[0]);
        chk("busy0", b0.busy, exp_busy[0]);
        chk("ovr0", b0.ovr, exp_ovr[0]);
        if (rd_known[0]) chk("rd_data0", b0.rd_data, exp_rd[0]);
        chk("rdy1", b1.rdy, exp_rdy[1]);
        chk("busy1", b1.busy, exp_busy[1]);
        chk("ovr1", b1.ovr, exp_ovr[1]);
        if (rd_known[1]) chk("rd_data1", b1.rd_data, exp_rd[1]);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            r_in[i] = 0;
            w_in[i] = 0;
            a_in[i] = '0;
            d_in[i] = '0;
        end
    endtask

    // One clock: model the coming posedge, then check at the following negedge
    task automatic tick();
        edge_no++;
        if (rst_n) begin
            model_edge(0, edge_no);
            model_edge(1, edge_no);
        end
        @(negedge clk);
        compare_all();
        clear_inputs();
    endtask

    // Called between edges; reset takes effect without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        edge_no++;
        compare_all();
        @(negedge clk);
        edge_no++;
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic wait_rdy(input int i, output int n);
        n = 0;
        while (!get_rdy(i) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            failures++;
            $display("FAIL wait_rdy%0d: got no rdy expected rdy within 40 cycles", i);
        end
    endtask

    task automatic req(input int i, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        r_in[i] = r;
        w_in[i] = w;
        a_in[i] = a;
        d_in[i] = d;
        tick();
    endtask

    initial begin
        int n;
        lat_m[0] = 4;  amask_m[0] = 32'hFFFF;
        lat_m[1] = 1;  amask_m[1] = 32'h00FF;
        edge_no = 0;
        clear_inputs();
        rst_n = 1'b1;
        model_reset();

        // Asynchronous reset before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rd_data", b0.rd_data, 16'h0000);
        chk("rst_rdy", b0.rdy, 1'b0);
        chk("rst_busy", b0.busy, 1'b0);
        chk("rst_ovr", b0.ovr, 1'b0);
        do_reset();

        // Write then read back, latency 4
        req(0, 0, 1, 16'h0010, 16'h1234);
        chk("busy_after_accept", b0.busy, 1'b1);
        wait_rdy(0, n);
        chk("wr_latency", n, 4);
        req(0, 1, 0, 16'h0010, 16'h0000);
        wait_rdy(0, n);
        chk("rd_latency", n, 4);
        chk("rd_0010", b0.rd_data, 16'h1234);

        // Back-to-back: request in the rdy cycle is accepted at once
        req(0, 0, 1, 16'h0011, 16'h5678);
        wait_rdy(0, n);
        req(0, 1, 0, 16'h0010, 16'h0000);
        wait_rdy(0, n);
        chk("b2b_latency", n, 4);
        chk("b2b_rd", b0.rd_data, 16'h1234);

        // Overrun: request while busy is ignored and ovr sticks
        req(0, 1, 0, 16'h0011, 16'h0000);
        req(0, 1, 0, 16'h0010, 16'h0000);
        wait_rdy(0, n);
        chk("ovr_latency", n, 3);
        chk("ovr_rd_first_req", b0.rd_data, 16'h5678);
        for (int k = 0; k < 6; k++) tick();
        chk("ovr_sticky", b0.ovr, 1'b1);

        // Reset mid-WAIT discards the pending write
        req(0, 0, 1, 16'h0020, 16'h1111);
        wait_rdy(0, n);
        req(0, 0, 1, 16'h0020, 16'hBEEF);
        tick();
        #2;
        do_reset();
        chk("ovr_cleared", b0.ovr, 1'b0);
        req(0, 1, 0, 16'h0020, 16'h0000);
        wait_rdy(0, n);
        chk("rd_after_abort", b0.rd_data, 16'h1111);

        // re&we together acts as a write
        req(0, 1, 0, 16'h0010, 16'h0000);
        wait_rdy(0, n);
        req(0, 1, 1, 16'h0030, 16'hA5A5);
        wait_rdy(0, n);
        chk("rewe_rd_hold", b0.rd_data, 16'h1234);
        req(0, 1, 0, 16'h0030, 16'h0000);
        wait_rdy(0, n);
        chk("rewe_written", b0.rd_data, 16'hA5A5);

        // Aliasing and LATENCY=1 on the narrow instance
        req(1, 0, 1, 16'h0105, 16'hC3C3);
        chk("lat1_busy", b1.busy, 1'b1);
        wait_rdy(1, n);
        chk("lat1_latency", n, 1);
        req(1, 1, 0, 16'h0005, 16'h0000);
        wait_rdy(1, n);
        chk("alias_rd", get_rd(1), 16'hC3C3);

        // Randomized traffic on both instances with occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 3))
                        0, 1: begin r_in[i] = 1; w_in[i] = 0; end
                        2:    begin r_in[i] = 0; w_in[i] = 1; end
                        default: begin r_in[i] = 1; w_in[i] = 1; end
                    endcase
                    a_in[i] = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
                    d_in[i] = 16'($urandom);
                end
            end
            tick();
            if (cyc % 500 == 499) begin
                #($urandom_range(1, 4));
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
